// File: rtl/eth_phy_10g_pkg.sv
// Shared definitions for the 10G RX PHY chain (gearbox, header aligner,
// block-lock). Holds the default datapath widths, the 66-bit block geometry
// and the two legal sync-header codes.
package eth_phy_10g_pkg;

  localparam int DEFAULT_IN_WIDTH   = 32;
  localparam int DEFAULT_HDR_WIDTH  = 2;
  localparam int DEFAULT_DATA_WIDTH = 64;

  // One 64b/66b block: 2-bit sync header followed by 64 payload bits.
  localparam int BLOCK_WIDTH = 66;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  // Gearbox storage: up to 65 leftover bits plus one 32-bit word.
  localparam int BUF_WIDTH  = 98;
  localparam int CNT_WIDTH  = 7;

  // Slip hold-off counter, wide enough for SLIP_HOLD up to 15.
  localparam int HOLD_WIDTH = 4;

endpackage

// File: rtl/eth_phy_10g_rx_gearbox_if.sv
// Bundle of the gearbox datapath signals.
//   serdes_rx_data / serdes_rx_valid : received SERDES word and qualifier
//   rx_bitslip                       : request to drop one received bit
//   serdes_rx_hdr / serdes_rx_data_out / serdes_rx_block_valid : 66-bit block out
//   rx_bitslip_busy                  : slip hold-off active
//   rx_slip_count / rx_block_count   : statistics, only with ETH_RX_GEARBOX_STATS_EN
// Modports: slave = the gearbox, master = the transceiver side / bench.
interface eth_phy_10g_rx_gearbox_if
  import eth_phy_10g_pkg::*;
#(
  parameter int IN_WIDTH   = DEFAULT_IN_WIDTH,
  parameter int HDR_WIDTH  = DEFAULT_HDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic [IN_WIDTH-1:0]   serdes_rx_data;
  logic                  serdes_rx_valid;
  logic                  rx_bitslip;
  logic [HDR_WIDTH-1:0]  serdes_rx_hdr;
  logic [DATA_WIDTH-1:0] serdes_rx_data_out;
  logic                  serdes_rx_block_valid;
  logic                  rx_bitslip_busy;
`ifdef ETH_RX_GEARBOX_STATS_EN
  logic [15:0]           rx_slip_count;
  logic [31:0]           rx_block_count;
`endif

  modport slave (
    input  serdes_rx_data,
    input  serdes_rx_valid,
    input  rx_bitslip,
    output serdes_rx_hdr,
    output serdes_rx_data_out,
    output serdes_rx_block_valid,
    output rx_bitslip_busy
`ifdef ETH_RX_GEARBOX_STATS_EN
    ,
    output rx_slip_count,
    output rx_block_count
`endif
  );

  modport master (
    output serdes_rx_data,
    output serdes_rx_valid,
    output rx_bitslip,
    input  serdes_rx_hdr,
    input  serdes_rx_data_out,
    input  serdes_rx_block_valid,
    input  rx_bitslip_busy
`ifdef ETH_RX_GEARBOX_STATS_EN
    ,
    input  rx_slip_count,
    input  rx_block_count
`endif
  );

endinterface

// File: rtl/eth_phy_10g_rx_slip_ctrl.sv
// Bitslip acceptance and hold-off for the RX gearbox.
//   clk, rst     : clock, asynchronous active-high reset
//   slip_req     : raw bitslip request
//   word_valid   : incoming SERDES word is valid this cycle
//   count_zero   : gearbox buffer holds no bits this cycle
//   busy         : hold-off active (requests are dropped)
//   slip_shift   : accepted slip removes the oldest buffered bit
//   drop_bits    : number of leading bits to drop from this cycle's word
// A slip that finds the buffer empty and no valid word is remembered and
// charged against the next valid word.
module eth_phy_10g_rx_slip_ctrl
  import eth_phy_10g_pkg::*;
#(
  parameter int SLIP_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slip_req,
  input  logic       word_valid,
  input  logic       count_zero,
  output logic       busy,
  output logic       slip_shift,
  output logic [1:0] drop_bits
);

  logic [HOLD_WIDTH-1:0] hold_reg, hold_next;
  logic                  deferred_reg, deferred_next;
  logic                  slip_accept;
  logic                  slip_on_word;

  assign busy         = (hold_reg != '0);
  assign slip_accept  = slip_req && !busy;
  assign slip_shift   = slip_accept && !count_zero;
  // Nothing buffered to drop: the slip has to come out of the incoming word.
  assign slip_on_word = slip_accept && count_zero;

  always_comb begin
    hold_next     = hold_reg;
    deferred_next = deferred_reg;
    drop_bits     = 2'd0;

    if (slip_accept) begin
      hold_next = HOLD_WIDTH'(SLIP_HOLD);
    end else if (busy) begin
      hold_next = hold_reg - 1'b1;
    end

    if (word_valid) begin
      // A pending deferred slip and a fresh one can both hit the same word.
      drop_bits     = {1'b0, deferred_reg} + {1'b0, slip_on_word};
      deferred_next = 1'b0;
    end else if (slip_on_word) begin
      deferred_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg     <= '0;
      deferred_reg <= 1'b0;
    end else begin
      hold_reg     <= hold_next;
      deferred_reg <= deferred_next;
    end
  end

endmodule

// File: rtl/eth_phy_10g_rx_gearbox.sv
// 32-bit to 66-bit RX gearbox with bitslip, feeding the header aligner.
// Ports:
//   clk   : single clock
//   rst   : asynchronous assert, synchronously released active-high reset
//   link  : eth_phy_10g_rx_gearbox_if.slave
//           in : serdes_rx_data (bit 0 oldest), serdes_rx_valid, rx_bitslip
//           out: serdes_rx_hdr = block bits [1:0], serdes_rx_data_out =
//                block bits [65:2], serdes_rx_block_valid (1-cycle strobe),
//                rx_bitslip_busy
// Optional build macro ETH_RX_GEARBOX_STATS_EN adds rx_slip_count
// (saturating accepted slips) and rx_block_count (wrapping emitted blocks).
// Each cycle: slip first, then append the valid word at the fill point,
// then emit a block if at least 66 bits are held.
module eth_phy_10g_rx_gearbox
  import eth_phy_10g_pkg::*;
#(
  parameter int IN_WIDTH   = DEFAULT_IN_WIDTH,
  parameter int HDR_WIDTH  = DEFAULT_HDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int SLIP_HOLD  = 4
) (
  input logic                   clk,
  input logic                   rst,
  eth_phy_10g_rx_gearbox_if.slave link
);

  if (IN_WIDTH != 32) begin : g_bad_in_width
    $error("eth_phy_10g_rx_gearbox: IN_WIDTH must be 32");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $error("eth_phy_10g_rx_gearbox: HDR_WIDTH must be 2");
  end
  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("eth_phy_10g_rx_gearbox: DATA_WIDTH must be 64");
  end
  if (SLIP_HOLD < 1 || SLIP_HOLD > 15) begin : g_bad_slip_hold
    $error("eth_phy_10g_rx_gearbox: SLIP_HOLD must be in 1..15");
  end

  localparam logic [CNT_WIDTH-1:0] BLOCK_COUNT = CNT_WIDTH'(BLOCK_WIDTH);
  localparam logic [CNT_WIDTH-1:0] WORD_COUNT  = CNT_WIDTH'(IN_WIDTH);

  logic [BUF_WIDTH-1:0]  bit_buf_reg, bit_buf_next;
  logic [CNT_WIDTH-1:0]  count_reg, count_next;
  logic [HDR_WIDTH-1:0]  hdr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  block_valid_reg;

  logic                  count_zero;
  logic                  busy;
  logic                  slip_shift;
  logic [1:0]            drop_bits;

  logic [BUF_WIDTH-1:0]  word_ext;
  logic [BUF_WIDTH-1:0]  buf_slip, buf_fill;
  logic [CNT_WIDTH-1:0]  count_slip, count_fill;
  logic                  emit;

  assign count_zero = (count_reg == '0);

  eth_phy_10g_rx_slip_ctrl #(
    .SLIP_HOLD (SLIP_HOLD)
  ) u_slip_ctrl (
    .clk        (clk),
    .rst        (rst),
    .slip_req   (link.rx_bitslip),
    .word_valid (link.serdes_rx_valid),
    .count_zero (count_zero),
    .busy       (busy),
    .slip_shift (slip_shift),
    .drop_bits  (drop_bits)
  );

  always_comb begin
    // Bits above the fill point are always zero, so appending is a plain OR.
    word_ext   = BUF_WIDTH'(link.serdes_rx_data >> drop_bits);
    buf_slip   = slip_shift ? (bit_buf_reg >> 1) : bit_buf_reg;
    count_slip = count_reg - CNT_WIDTH'(slip_shift);

    buf_fill   = buf_slip;
    count_fill = count_slip;
    if (link.serdes_rx_valid) begin
      buf_fill   = buf_slip | (word_ext << count_slip);
      count_fill = count_slip + WORD_COUNT - CNT_WIDTH'(drop_bits);
    end

    // Count is at most 65 entering a cycle, so one emit per cycle suffices.
    emit         = (count_fill >= BLOCK_COUNT);
    bit_buf_next = buf_fill;
    count_next   = count_fill;
    if (emit) begin
      bit_buf_next = buf_fill >> BLOCK_WIDTH;
      count_next   = count_fill - BLOCK_COUNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_buf_reg     <= '0;
      count_reg       <= '0;
      hdr_reg         <= '0;
      data_reg        <= '0;
      block_valid_reg <= 1'b0;
    end else begin
      bit_buf_reg     <= bit_buf_next;
      count_reg       <= count_next;
      block_valid_reg <= emit;
      if (emit) begin
        hdr_reg  <= buf_fill[HDR_WIDTH-1:0];
        data_reg <= buf_fill[BLOCK_WIDTH-1:HDR_WIDTH];
      end
    end
  end

  assign link.serdes_rx_hdr         = hdr_reg;
  assign link.serdes_rx_data_out    = data_reg;
  assign link.serdes_rx_block_valid = block_valid_reg;
  assign link.rx_bitslip_busy       = busy;

`ifdef ETH_RX_GEARBOX_STATS_EN
  logic [15:0] slip_count_reg;
  logic [31:0] block_count_reg;
  logic        slip_accept;

  assign slip_accept = link.rx_bitslip && !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slip_count_reg  <= '0;
      block_count_reg <= '0;
    end else begin
      if (slip_accept && (slip_count_reg != 16'hFFFF)) begin
        slip_count_reg <= slip_count_reg + 1'b1;
      end
      if (emit) begin
        block_count_reg <= block_count_reg + 1'b1;
      end
    end
  end

  assign link.rx_slip_count  = slip_count_reg;
  assign link.rx_block_count = block_count_reg;
`endif

endmodule
